// File: rtl/fd_ts_delta_monitor_if.sv
// -----------------------------------------------------------------------------
// fd_ts_delta_monitor_if
// Timestamp input channel of the fine-delay timestamp interval monitor.
// Carries one tagged (utc, coarse, frac) timestamp per valid/ready handshake.
//
// Signals
//   ts_valid   master -> slave  timestamp valid
//   ts_ready   slave  -> master monitor can accept the timestamp
//   ts_chan    master -> slave  channel index
//   ts_utc     master -> slave  UTC seconds
//   ts_coarse  master -> slave  coarse ticks within the second
//   ts_frac    master -> slave  fractional part of a coarse tick
//
// Modports
//   master  timestamp producer (FIFO readout or testbench)
//   slave   timestamp consumer (the monitor)
// -----------------------------------------------------------------------------
interface fd_ts_delta_monitor_if #(
  parameter int g_num_channels = 4,
  parameter int g_utc_bits     = 32,
  parameter int g_coarse_bits  = 28,
  parameter int g_frac_bits    = 12
);

  localparam int C = (g_num_channels > 1) ? $clog2(g_num_channels) : 1;

  logic                     ts_valid;
  logic                     ts_ready;
  logic [C-1:0]             ts_chan;
  logic [g_utc_bits-1:0]    ts_utc;
  logic [g_coarse_bits-1:0] ts_coarse;
  logic [g_frac_bits-1:0]   ts_frac;

  modport master (
    output ts_valid,
    output ts_chan,
    output ts_utc,
    output ts_coarse,
    output ts_frac,
    input  ts_ready
  );

  modport slave (
    input  ts_valid,
    input  ts_chan,
    input  ts_utc,
    input  ts_coarse,
    input  ts_frac,
    output ts_ready
  );

endinterface

// File: rtl/fd_ts_delta_monitor.sv
// -----------------------------------------------------------------------------
// fd_ts_delta_monitor
// Multi-channel timestamp interval checker for fine-delay TDC verification and
// self-test. For every channel it keeps the previous timestamp, computes the
// interval to the new one in frac units (8 ns / 2^g_frac_bits), checks it
// against an inclusive [min, max] window and keeps saturating pass/fail
// counters plus a sticky per-channel error flag.
//
// Ports
//   clk_sys_i    in   system clock
//   rst_i        in   synchronous reset, active high
//   ts           slave  timestamp handshake (valid/ready, chan, utc, coarse, frac)
//   cfg_en_i     in   per-channel enable; disabling a channel drops its history
//   cfg_min_i    in   window lower bound, inclusive
//   cfg_max_i    in   window upper bound, inclusive
//   clr_i        in   clear history, counters and sticky errors
//   dlt_valid_o  out  one-cycle result strobe
//   dlt_chan_o   out  channel of the result
//   dlt_value_o  out  interval in frac units, saturated
//   dlt_ok_o     out  interval inside the window
//   pass_cnt_o   out  packed per-channel pass counters, channel 0 in LSBs
//   fail_cnt_o   out  packed per-channel fail counters, channel 0 in LSBs
//   err_o        out  sticky per-channel fail flags
//
// Pipeline: S1 registers the raw utc/coarse/frac differences and updates the
// channel history; S2 turns them into a saturated, classified interval.
// Accept -> dlt_valid_o is two cycles, one accept per cycle sustained.
// -----------------------------------------------------------------------------
module fd_ts_delta_monitor #(
  parameter int g_num_channels = 4,
  parameter int g_utc_bits     = 32,
  parameter int g_coarse_bits  = 28,
  parameter int g_frac_bits    = 12,
  parameter int g_coarse_max   = 125000000,
  parameter int g_delta_bits   = 32,
  parameter int g_cnt_bits     = 16,
  localparam int C = (g_num_channels > 1) ? $clog2(g_num_channels) : 1
) (
  input  logic                               clk_sys_i,
  input  logic                               rst_i,
  fd_ts_delta_monitor_if.slave               ts,
  input  logic [g_num_channels-1:0]          cfg_en_i,
  input  logic [g_delta_bits-1:0]            cfg_min_i,
  input  logic [g_delta_bits-1:0]            cfg_max_i,
  input  logic                               clr_i,
  output logic                               dlt_valid_o,
  output logic [C-1:0]                       dlt_chan_o,
  output logic [g_delta_bits-1:0]            dlt_value_o,
  output logic                               dlt_ok_o,
  output logic [g_num_channels*g_cnt_bits-1:0] pass_cnt_o,
  output logic [g_num_channels*g_cnt_bits-1:0] fail_cnt_o,
  output logic [g_num_channels-1:0]          err_o
);

  // Signed difference widths: one extra bit over the unsigned operands.
  localparam int CW = g_coarse_bits + 1;
  localparam int FW = g_frac_bits + 1;

  // Interval arithmetic width. (dc + coarse_max) fits in 34 signed bits for
  // coarse widths up to 32; shifting by F and adding df needs F+1 more. The
  // width must also exceed the delta width so overflow can be detected.
  localparam int BW0 = ((g_coarse_bits > 32) ? g_coarse_bits : 32) + 2 + g_frac_bits + 1;
  localparam int IW  = (BW0 > g_delta_bits + 1) ? BW0 : g_delta_bits + 2;

  localparam logic [IW-1:0]         LP_CMAX    = IW'(g_coarse_max);
  localparam logic [IW-1:0]         LP_DMAX    = {{(IW-g_delta_bits){1'b0}}, {g_delta_bits{1'b1}}};
  localparam logic [g_utc_bits-1:0] LP_UTC_ONE = {{(g_utc_bits-1){1'b0}}, 1'b1};
  localparam logic [g_cnt_bits-1:0] LP_CNT_MAX = '1;

  // Input-side decode
  logic                      w_accept;
  logic [g_num_channels-1:0] w_hit;
  logic                      w_load;
  logic                      w_hasHist;
  logic [g_utc_bits-1:0]     w_prevUtc;
  logic [g_coarse_bits-1:0]  w_prevCoarse;
  logic [g_frac_bits-1:0]    w_prevFrac;
  logic [g_utc_bits-1:0]     w_dUtc;
  logic [CW-1:0]             w_dCoarse;
  logic [FW-1:0]             w_dFrac;

  // Per-channel history
  logic [g_num_channels-1:0] r_histValid;
  logic [g_utc_bits-1:0]     r_prevUtc    [g_num_channels];
  logic [g_coarse_bits-1:0]  r_prevCoarse [g_num_channels];
  logic [g_frac_bits-1:0]    r_prevFrac   [g_num_channels];

  // S1 pipeline register
  logic                  r_s1Valid;
  logic [C-1:0]          r_s1Chan;
  logic [g_utc_bits-1:0] r_s1DUtc;
  logic [CW-1:0]         r_s1DCoarse;
  logic [FW-1:0]         r_s1DFrac;

  // S2 combinational classification
  logic [IW-1:0]           w_dCoarseExt;
  logic [IW-1:0]           w_dFracExt;
  logic [IW-1:0]           w_base;
  logic [IW-1:0]           w_interval;
  logic [g_delta_bits-1:0] w_value;
  logic                    w_ok;

  // Result and statistics registers
  logic                      r_dltValid;
  logic [C-1:0]              r_dltChan;
  logic [g_delta_bits-1:0]   r_dltValue;
  logic                      r_dltOk;
  logic [g_cnt_bits-1:0]     r_passCnt [g_num_channels];
  logic [g_cnt_bits-1:0]     r_failCnt [g_num_channels];
  logic [g_num_channels-1:0] r_err;

  // Ready drops for the reset and clear cycles so nothing is accepted while
  // history is being wiped.
  assign ts.ts_ready = !rst_i && !clr_i;
  assign w_accept    = ts.ts_valid && ts.ts_ready;

  // One-hot channel decode and history mux. An out-of-range channel matches
  // nothing, so it can neither load history nor produce a result.
  always_comb begin
    w_hit        = '0;
    w_prevUtc    = '0;
    w_prevCoarse = '0;
    w_prevFrac   = '0;
    for (int i = 0; i < g_num_channels; i++) begin
      if (ts.ts_chan == C'(i)) begin
        w_hit[i]     = 1'b1;
        w_prevUtc    = r_prevUtc[i];
        w_prevCoarse = r_prevCoarse[i];
        w_prevFrac   = r_prevFrac[i];
      end
    end
  end

  assign w_load    = w_accept && |(w_hit & cfg_en_i);
  assign w_hasHist = |(w_hit & r_histValid);

  // UTC difference is modular: 0 and 1 are the only usable values, anything
  // else (including a step backwards) is classified as a failure in S2.
  assign w_dUtc    = ts.ts_utc - w_prevUtc;
  assign w_dCoarse = {1'b0, ts.ts_coarse} - {1'b0, w_prevCoarse};
  assign w_dFrac   = {1'b0, ts.ts_frac} - {1'b0, w_prevFrac};

  // History-valid flags. Clear and reset wipe all of them; a disabled channel
  // keeps its flag cleared so re-enabling starts from a fresh first timestamp.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || clr_i) begin
      r_histValid <= '0;
    end else begin
      for (int i = 0; i < g_num_channels; i++) begin
        if (!cfg_en_i[i]) begin
          r_histValid[i] <= 1'b0;
        end else if (w_load && w_hit[i]) begin
          r_histValid[i] <= 1'b1;
        end
      end
    end
  end

  // Previous timestamp per channel, loaded on every accepted timestamp so a
  // back-to-back accept on the same channel sees the new history. These carry
  // no reset: they are only read while the matching history flag is set.
  always_ff @(posedge clk_sys_i) begin
    for (int i = 0; i < g_num_channels; i++) begin
      if (w_load && w_hit[i]) begin
        r_prevUtc[i]    <= ts.ts_utc;
        r_prevCoarse[i] <= ts.ts_coarse;
        r_prevFrac[i]   <= ts.ts_frac;
      end
    end
  end

  // S1: register the raw differences. A first timestamp on a channel only
  // loads history, so it does not enter the pipeline.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_s1Valid   <= 1'b0;
      r_s1Chan    <= '0;
      r_s1DUtc    <= '0;
      r_s1DCoarse <= '0;
      r_s1DFrac   <= '0;
    end else begin
      r_s1Valid <= w_load && w_hasHist;
      if (w_load) begin
        r_s1Chan    <= ts.ts_chan;
        r_s1DUtc    <= w_dUtc;
        r_s1DCoarse <= w_dCoarse;
        r_s1DFrac   <= w_dFrac;
      end
    end
  end

  // S2: build the signed interval (dc [+ coarse_max]) * 2^F + df and clamp it.
  // Non-positive intervals saturate to 0 and fail, intervals above the delta
  // range saturate to all-ones and fail, and only in-range values are
  // compared against the window.
  always_comb begin
    w_dCoarseExt = {{(IW-CW){r_s1DCoarse[CW-1]}}, r_s1DCoarse};
    w_dFracExt   = {{(IW-FW){r_s1DFrac[FW-1]}}, r_s1DFrac};
    w_base       = (r_s1DUtc == LP_UTC_ONE) ? (w_dCoarseExt + LP_CMAX) : w_dCoarseExt;
    w_interval   = (w_base << g_frac_bits) + w_dFracExt;
    w_value      = '0;
    w_ok         = 1'b0;
    if ((r_s1DUtc != '0) && (r_s1DUtc != LP_UTC_ONE)) begin
      w_value = '1;
    end else if (w_interval[IW-1] || (w_interval == '0)) begin
      w_value = '0;
    end else if (w_interval > LP_DMAX) begin
      w_value = '1;
    end else begin
      w_value = w_interval[g_delta_bits-1:0];
      w_ok    = (w_value >= cfg_min_i) && (w_value <= cfg_max_i);
    end
  end

  // Result register; it only moves when S1 carries a result so the outputs
  // stay quiet between strobes.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i) begin
      r_dltValid <= 1'b0;
      r_dltChan  <= '0;
      r_dltValue <= '0;
      r_dltOk    <= 1'b0;
    end else begin
      r_dltValid <= r_s1Valid;
      if (r_s1Valid) begin
        r_dltChan  <= r_s1Chan;
        r_dltValue <= w_value;
        r_dltOk    <= w_ok;
      end
    end
  end

  // Counters and sticky errors update on the same edge that launches the
  // result strobe. Clear takes priority, so a result still in flight during
  // the clear is emitted but never counted.
  always_ff @(posedge clk_sys_i) begin
    if (rst_i || clr_i) begin
      for (int i = 0; i < g_num_channels; i++) begin
        r_passCnt[i] <= '0;
        r_failCnt[i] <= '0;
      end
      r_err <= '0;
    end else if (r_s1Valid) begin
      for (int i = 0; i < g_num_channels; i++) begin
        if (r_s1Chan == C'(i)) begin
          if (w_ok) begin
            if (r_passCnt[i] != LP_CNT_MAX) begin
              r_passCnt[i] <= r_passCnt[i] + 1'b1;
            end
          end else begin
            if (r_failCnt[i] != LP_CNT_MAX) begin
              r_failCnt[i] <= r_failCnt[i] + 1'b1;
            end
            r_err[i] <= 1'b1;
          end
        end
      end
    end
  end

  // Pack the counter arrays, channel 0 in the LSBs.
  always_comb begin
    pass_cnt_o = '0;
    fail_cnt_o = '0;
    for (int i = 0; i < g_num_channels; i++) begin
      pass_cnt_o[i*g_cnt_bits +: g_cnt_bits] = r_passCnt[i];
      fail_cnt_o[i*g_cnt_bits +: g_cnt_bits] = r_failCnt[i];
    end
  end

  assign dlt_valid_o = r_dltValid;
  assign dlt_chan_o  = r_dltChan;
  assign dlt_value_o = r_dltValue;
  assign dlt_ok_o    = r_dltOk;
  assign err_o       = r_err;

endmodule

// File: tb/tb_fd_ts_delta_monitor.sv
// -----------------------------------------------------------------------------
// tb_fd_ts_delta_monitor
// Directed testbench for fd_ts_delta_monitor. Five channels (so channel
// codes 5..7 are out of range on the 3-bit channel field) and 4-bit counters
// (so saturation is reachable in a few cycles). Expected intervals are worked
// out by hand from (dc [+ 125000000]) * 4096 + df.
// -----------------------------------------------------------------------------
module tb_fd_ts_delta_monitor;

  localparam int N  = 5;
  localparam int CB = 4;
  localparam int D  = 32;
  localparam int C  = 3;
  localparam logic [63:0] ALL_ONES = 64'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst;
  logic          clr;
  logic [N-1:0]  cfgEn;
  logic [D-1:0]  cfgMin;
  logic [D-1:0]  cfgMax;
  logic          dltValid;
  logic [C-1:0]  dltChan;
  logic [D-1:0]  dltValue;
  logic          dltOk;
  logic [N*CB-1:0] passCnt;
  logic [N*CB-1:0] failCnt;
  logic [N-1:0]  err;

  int checks = 0;
  int errors = 0;
  int passExp [N];
  int failExp [N];
  logic [N-1:0] errExp;

  fd_ts_delta_monitor_if #(.g_num_channels(N)) tsIf ();

  fd_ts_delta_monitor #(
    .g_num_channels (N),
    .g_cnt_bits     (CB)
  ) dut (
    .clk_sys_i   (clk),
    .rst_i       (rst),
    .ts          (tsIf),
    .cfg_en_i    (cfgEn),
    .cfg_min_i   (cfgMin),
    .cfg_max_i   (cfgMax),
    .clr_i       (clr),
    .dlt_valid_o (dltValid),
    .dlt_chan_o  (dltChan),
    .dlt_value_o (dltValue),
    .dlt_ok_o    (dltOk),
    .pass_cnt_o  (passCnt),
    .fail_cnt_o  (failCnt),
    .err_o       (err)
  );

  always #5 clk = ~clk;

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // Present one timestamp for exactly one clock edge.
  task automatic applyStimulus(input int ch, input int utc, input int coarse, input int frac);
    tsIf.ts_valid  = 1'b1;
    tsIf.ts_chan   = ch[C-1:0];
    tsIf.ts_utc    = utc;
    tsIf.ts_coarse = coarse[27:0];
    tsIf.ts_frac   = frac[11:0];
    step();
    tsIf.ts_valid  = 1'b0;
  endtask

  task automatic checkNone(input string tag);
    checkOutput(tag, 64'(dltValid), 64'd0);
  endtask

  // Check the current result; when counted, fold it into the counter model.
  task automatic checkResult(input string tag, input int ch, input logic [63:0] value,
                             input bit ok, input bit counted);
    checkOutput({tag, ".valid"}, 64'(dltValid), 64'd1);
    checkOutput({tag, ".chan"},  64'(dltChan),  64'(ch));
    checkOutput({tag, ".value"}, 64'(dltValue), value);
    checkOutput({tag, ".ok"},    64'(dltOk),    64'(ok));
    if (counted) begin
      if (ok) begin
        if (passExp[ch] < 15) passExp[ch]++;
      end else begin
        if (failExp[ch] < 15) failExp[ch]++;
        errExp[ch] = 1'b1;
      end
    end
  endtask

  task automatic checkCounters(input string tag);
    for (int i = 0; i < N; i++) begin
      checkOutput($sformatf("%s.pass%0d", tag, i), 64'(passCnt[i*CB +: CB]), 64'(passExp[i]));
      checkOutput($sformatf("%s.fail%0d", tag, i), 64'(failCnt[i*CB +: CB]), 64'(failExp[i]));
    end
    checkOutput({tag, ".err"}, 64'(err), 64'(errExp));
  endtask

  task automatic clearModel();
    for (int i = 0; i < N; i++) begin
      passExp[i] = 0;
      failExp[i] = 0;
    end
    errExp = '0;
  endtask

  initial begin
    rst            = 1'b1;
    clr            = 1'b0;
    cfgEn          = '1;
    cfgMin         = 32'd128000;
    cfgMax         = 32'd129000;
    tsIf.ts_valid  = 1'b0;
    tsIf.ts_chan   = '0;
    tsIf.ts_utc    = '0;
    tsIf.ts_coarse = '0;
    tsIf.ts_frac   = '0;
    clearModel();

    // Reset state
    repeat (3) step();
    checkOutput("reset.ready", 64'(tsIf.ts_ready), 64'd0);
    checkNone("reset.dltValid");
    checkOutput("reset.dltValue", 64'(dltValue), 64'd0);
    checkOutput("reset.dltOk", 64'(dltOk), 64'd0);
    checkCounters("reset");
    rst = 1'b0;
    #1;
    checkOutput("postReset.ready", 64'(tsIf.ts_ready), 64'd1);

    // Same-second interval: 31 ticks + 1593 frac = 128569
    applyStimulus(0, 0, 100, 0);
    step();
    checkNone("t1.first");
    applyStimulus(0, 0, 131, 1593);
    step();
    checkResult("t1", 0, 64'd128569, 1'b1, 1'b1);
    checkCounters("t1");

    // Second rollover: (20-124999990+125000000)*4096 + (100-4000) = 118980
    cfgMin = 32'd0;
    cfgMax = 32'd200000;
    applyStimulus(1, 5, 124999990, 4000);
    step();
    checkNone("t2.first");
    applyStimulus(1, 6, 20, 100);
    step();
    checkResult("t2.wrap", 1, 64'd118980, 1'b1, 1'b1);
    applyStimulus(1, 8, 0, 0);
    step();
    checkResult("t2.utcJump", 1, ALL_ONES, 1'b0, 1'b1);
    checkCounters("t2");

    // Non-monotonic and zero intervals clamp to 0; huge interval to all-ones
    applyStimulus(2, 0, 50, 10);
    step();
    checkNone("t3.first");
    applyStimulus(2, 0, 50, 5);
    step();
    checkResult("t3.backwards", 2, 64'd0, 1'b0, 1'b1);
    applyStimulus(2, 0, 50, 5);
    step();
    checkResult("t3.equal", 2, 64'd0, 1'b0, 1'b1);
    applyStimulus(2, 1, 0, 0);
    step();
    checkResult("t3.overflow", 2, ALL_ONES, 1'b0, 1'b1);
    checkCounters("t3");

    // Clear, then interleaved back-to-back accepts with a one-point window
    clr = 1'b1;
    #1;
    checkOutput("t4.clrReady", 64'(tsIf.ts_ready), 64'd0);
    step();
    clr = 1'b0;
    clearModel();
    checkCounters("t4.clr");
    cfgMin = 32'd128569;
    cfgMax = 32'd128569;
    applyStimulus(0, 0, 1000, 0);
    applyStimulus(1, 0, 2000, 100);
    checkNone("t4.loadA");
    applyStimulus(0, 0, 1031, 1593);
    checkNone("t4.loadB");
    applyStimulus(1, 0, 2031, 1693);
    checkResult("t4.ch0", 0, 64'd128569, 1'b1, 1'b1);
    step();
    checkResult("t4.ch1", 1, 64'd128569, 1'b1, 1'b1);
    step();
    checkNone("t4.drain");
    checkCounters("t4");

    // Dropped accepts: disabled channel and out-of-range channel codes
    cfgEn = 5'b11110;
    step();
    applyStimulus(0, 0, 1062, 3186);
    step();
    checkNone("t6.disabled");
    applyStimulus(5, 0, 10, 0);
    applyStimulus(5, 0, 41, 0);
    step();
    checkNone("t6.chan5");
    applyStimulus(7, 0, 10, 0);
    applyStimulus(7, 0, 41, 0);
    step();
    checkNone("t6.chan7");
    checkCounters("t6.dropped");
    cfgEn = '1;
    applyStimulus(0, 0, 2000, 0);
    step();
    checkNone("t6.reenable");

    // Reset while a result sits in S1
    applyStimulus(0, 0, 2031, 1593);
    rst = 1'b1;
    #1;
    checkOutput("t6.rstReady", 64'(tsIf.ts_ready), 64'd0);
    step();
    checkNone("t6.flush");
    checkOutput("t6.rstValue", 64'(dltValue), 64'd0);
    clearModel();
    checkCounters("t6.rst");
    step();
    checkNone("t6.flush2");
    rst = 1'b0;
    #1;
    checkOutput("t6.postRstReady", 64'(tsIf.ts_ready), 64'd1);

    // Counter saturation: 21 timestamps 40 ticks apart -> 20 passes of 163840
    cfgMin = 32'd0;
    cfgMax = 32'd200000;
    for (int k = 0; k < 21; k++) begin
      applyStimulus(3, 0, 100 + 40 * k, 0);
    end
    step();
    checkResult("t5.last", 3, 64'd163840, 1'b1, 1'b0);
    passExp[3] = 15;
    checkCounters("t5.sat");
    step();
    checkNone("t5.drain");

    // Clear with a result in flight: it is emitted but not counted
    applyStimulus(3, 0, 940, 0);
    clr = 1'b1;
    #1;
    checkOutput("t5.clrReady", 64'(tsIf.ts_ready), 64'd0);
    step();
    clr = 1'b0;
    checkResult("t5.inflight", 3, 64'd163840, 1'b1, 1'b0);
    clearModel();
    checkCounters("t5.clr");
    applyStimulus(3, 0, 980, 0);
    step();
    checkNone("t5.fresh");
    step();
    checkNone("t5.fresh2");
    checkCounters("t5.end");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
